// File: rtl/sequence_serializer.sv
// Word FIFO feeding an MSB-first parallel-to-serial shifter.
// Consecutive queued words are emitted back to back with no idle cycle between them.
module sequence_serializer #(
    parameter int WORD_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [WORD_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          out,
    output logic                          out_valid,
    output logic                          first,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(WORD_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nx;
    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt;
    logic [WORD_W-1:0]   shreg;
    logic                push, pop;

    assign in_ready = (level != (AW+1)'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    // Pop decisions use the pre-edge level, so a same-edge push is never popped.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop      = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    if (level != '0) pop = 1'b1;
                    else             state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            cnt    <= '0;
            shreg  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (pop) begin
                shreg <= mem[rd_ptr];
                cnt   <= CNT_MAX;
            end else if (state == SHIFT) begin
                shreg <= {shreg[WORD_W-2:0], 1'b0};
                cnt   <= (cnt == '0) ? '0 : cnt - CW'(1);
            end
        end
    end

    assign out_valid = (state == SHIFT);
    assign out       = out_valid & shreg[WORD_W-1];
    assign first     = out_valid && (cnt == CNT_MAX);

endmodule

// File: tb/tb_sequence_serializer.sv
// Directed bench for sequence_serializer: cycle table for single-word and boundary
// timing, then hand-written stream, backpressure and asynchronous-reset sequences.
module tb_sequence_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready, out, out_valid, first;
    logic [2:0] level;

    int n_tests = 0;
    int n_fail  = 0;

    logic exp_q[$];
    int   pos;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       ov, o, f, rdy;
        logic [2:0] lvl;
    } vec_t;

    vec_t tbl[18];

    sequence_serializer #(.WORD_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .first(first),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input logic v, input logic [3:0] d, input logic ov,
                           input logic o, input logic f, input logic rdy, input logic [2:0] lvl);
        tbl[i].v = v; tbl[i].d = d; tbl[i].ov = ov; tbl[i].o = o;
        tbl[i].f = f; tbl[i].rdy = rdy; tbl[i].lvl = lvl;
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[b]);
    endtask

    // Compares the current serial bit against the expected stream.
    task automatic mon(input bit gapcheck);
        if (out_valid) begin
            if (pos < exp_q.size()) begin
                chk("bit", {31'b0, out}, {31'b0, exp_q[pos]});
                chk("first", {31'b0, first}, {31'b0, (pos % 4) == 0});
            end else begin
                chk("extra_bit", {31'b0, out_valid}, 32'd0);
            end
            pos++;
        end else if (gapcheck && pos > 0 && pos < exp_q.size()) begin
            chk("gap", {31'b0, out_valid}, 32'd1);
        end
    endtask

    initial begin
        int idx;

        set_row( 0, 1, 4'hB, 0, 0, 0, 1, 0);
        set_row( 1, 0, 4'h0, 0, 0, 0, 1, 1);
        set_row( 2, 0, 4'h0, 1, 1, 1, 1, 0);
        set_row( 3, 0, 4'h0, 1, 0, 0, 1, 0);
        set_row( 4, 0, 4'h0, 1, 1, 0, 1, 0);
        set_row( 5, 0, 4'h0, 1, 1, 0, 1, 0);
        set_row( 6, 1, 4'h6, 0, 0, 0, 1, 0);
        set_row( 7, 0, 4'h0, 0, 0, 0, 1, 1);
        set_row( 8, 0, 4'h0, 1, 0, 1, 1, 0);
        set_row( 9, 0, 4'h0, 1, 1, 0, 1, 0);
        set_row(10, 0, 4'h0, 1, 1, 0, 1, 0);
        set_row(11, 1, 4'h5, 1, 0, 0, 1, 0);
        set_row(12, 0, 4'h0, 0, 0, 0, 1, 1);
        set_row(13, 0, 4'h0, 1, 0, 1, 1, 0);
        set_row(14, 0, 4'h0, 1, 1, 0, 1, 0);
        set_row(15, 0, 4'h0, 1, 0, 0, 1, 0);
        set_row(16, 0, 4'h0, 1, 1, 0, 1, 0);
        set_row(17, 0, 4'h0, 0, 0, 0, 1, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        #2;
        chk("reset_outs", {27'b0, out_valid, out, first, in_ready, level}, {27'b0, 7'b0001000});
        #10 rst_n = 1'b1;

        // Single word, then push on the last bit of a word with empty FIFO.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d", i), {25'b0, out_valid, out, first, in_ready, level},
                {25'b0, tbl[i].ov, tbl[i].o, tbl[i].f, tbl[i].rdy, tbl[i].lvl});
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
        end

        // Continuous stream 0..F: 64 gapless bits.
        exp_q.delete(); pos = 0; idx = 0;
        for (int w = 0; w < 16; w++) push_word(4'(w));
        for (int c = 0; c < 300 && pos < 64; c++) begin
            @(negedge clk);
            mon(1'b1);
            if (in_ready && idx < 16) begin
                in_valid = 1'b1; in_data = 4'(idx); idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("stream_bits", pos, 64);
        @(negedge clk);
        chk("stream_idle", {31'b0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);

        // Backpressure: six back-to-back words, sixth held while full.
        begin
            logic [3:0] words[6];
            logic [2:0] exp_lvl[8];
            words   = '{4'h9, 4'h3, 4'hC, 4'h5, 4'hA, 4'h6};
            exp_lvl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
            exp_q.delete(); pos = 0; idx = 0;
            for (int w = 0; w < 6; w++) push_word(words[w]);
            for (int c = 0; c < 150 && pos < 24; c++) begin
                @(negedge clk);
                mon(1'b0);
                if (c < 8) begin
                    chk($sformatf("bp_level%0d", c), {29'b0, level}, {29'b0, exp_lvl[c]});
                    chk($sformatf("bp_ready%0d", c), {31'b0, in_ready}, {31'b0, exp_lvl[c] != 3'd4});
                end
                if (idx < 6) begin
                    in_valid = 1'b1; in_data = words[idx];
                    if (in_ready) idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            chk("bp_bits", pos, 24);
        end
        repeat (4) @(negedge clk);

        // Asynchronous reset during a word with three more queued.
        exp_q.delete(); pos = 0;
        push_word(4'hC);
        in_valid = 1'b1; in_data = 4'hC; @(negedge clk); mon(1'b0);
        in_data = 4'h9; @(negedge clk); mon(1'b0);
        in_data = 4'hA; @(negedge clk); mon(1'b0);
        in_data = 4'h3; @(negedge clk); mon(1'b0);
        in_valid = 1'b0;
        chk("pre_rst_level", {29'b0, level}, 32'd3);
        chk("pre_rst_pos", pos, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {27'b0, out_valid, out, first, in_ready, level}, {27'b0, 7'b0001000});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = 4'h6;
        exp_q.delete(); pos = 0;
        push_word(4'h6);
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_level", {29'b0, level}, 32'd1);
        chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mon(1'b1);
        end
        chk("post_rst_bits", pos, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_serializer.md
SEQUENCE_SERIALIZER -- requirements
Module: sequence_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 4, the width of one input word in bits (≥2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of buffered words (power of 2, ≥2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  the producer offers in_data this cycle.
REQ-006 SHALL have port in_data  input  WORD_W  the word to transmit, sent MSB first.
REQ-007 SHALL have port in_ready  output  1  the FIFO can accept a word this cycle.
REQ-008 SHALL have port out  output  1  the serial bit stream.
REQ-009 SHALL have port out_valid  output  1  out carries a valid data bit this cycle.
REQ-010 SHALL have port first  output  1  out carries the MSB (the first bit) of a word.
REQ-011 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  the number of words held in the FIFO.

Function
REQ-012 SHALL accept a word on each rising edge where in_valid && in_ready (push), storing it in an in-order FIFO.
REQ-013 SHALL drive in_ready = (level != FIFO_DEPTH), combinationally from the registered level only, with no dependence on in_valid.
REQ-014 SHALL ignore in_data whenever in_valid is low or in_ready is low; a refused word is not stored and no state changes.
REQ-015 SHALL implement a two-state FSM: IDLE (out_valid=0) and SHIFT (out_valid=1).
REQ-016 IDLE: on an edge with level>0, SHALL pop the head word into the shift register, load bit counter = WORD_W-1, and enter SHIFT.
REQ-017 SHIFT: SHALL drive out = shift register MSB; on each edge, SHALL shift left by one bit and decrement the counter.
REQ-018 SHIFT with counter==0: on that edge, if level>0, SHALL pop and load the next word and stay in SHIFT (gapless, no idle cycle); otherwise SHALL enter IDLE.
REQ-019 SHALL base the pop decision on level before the edge; a word pushed on the same edge is not eligible for that pop.
REQ-020 On an edge with simultaneous push and pop, SHALL leave level unchanged and keep the FIFO in order.
REQ-021 SHALL wrap read/write pointers modulo FIFO_DEPTH; with in_ready held correctly, the FIFO never overflows or underflows.
REQ-022 SHALL assert first only during the first bit (counter==WORD_W-1) of each word in SHIFT.
REQ-023 SHALL drive out=0 and first=0 whenever out_valid=0.
REQ-024 Latency: a word pushed into an empty FIFO while IDLE at edge E SHALL show its MSB on out in the cycle after edge E+1, and its bits in the WORD_W cycles following E+1.
REQ-025 SHALL drive out, out_valid and first from registers (no combinational path from inputs).

Reset
REQ-026 When rst_n=0, SHALL immediately force: state IDLE, level=0, pointers=0, counter=0, shift register=0, out=0, out_valid=0, first=0, in_ready=1.
REQ-027 A reset asserted mid-word or with a non-empty FIFO SHALL discard all buffered and partial words; the first word after reset starts with first=1.
REQ-028 A push attempted in the cycle rst_n rises SHALL be accepted normally on the next rising edge.

Verification
REQ-029 Single word: push 4'b1011 into an idle, empty block -> out=1,0,1,1 on 4 consecutive cycles, out_valid high exactly 4 cycles, first high on cycle 1 only, then IDLE.
REQ-030 Stream: hold in_valid=1 with in_data counting 0x0..0xF, advancing on each accepted push -> exactly 64 contiguous valid bits 0000 0001 … 1111, first every 4th cycle, no gaps.
REQ-031 Backpressure: push 6 words back-to-back while the first word is shifting -> in_ready falls when level=4, the 6th word is held until in_ready rises, and all 6 words arrive in order.
REQ-032 Boundary: push on the same edge as the last bit of a word with level=0 -> out_valid drops for exactly one cycle, then the new word starts with first=1.
REQ-033 Reset mid-operation: assert rst_n=0 asynchronously during bit 2 of 4'b1100 with 3 words queued -> outputs clear immediately without waiting for clk, level=0, and after release a fresh push of 4'b0110 emits 0,1,1,0.
